// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_LINK_REG = 31;
    localparam int ZERO_REG     = 0;

    // Jump-and-link redirect: the link register replaces the supplied index.
    function automatic int eff_addr(input logic jal, input int addr, input int link_reg);
        return jal ? link_reg : addr;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Single-bit busy scoreboard: writeback clears, reserve sets, reserve wins on a collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   weff_i,
    input  logic                rsv_en_i,
    input  logic [ADDR_W-1:0]   reff_i,
    output logic [NUM_REGS-1:0] busy_vec_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (wr_en_i && weff_i != ADDR_W'(ZERO_REG)) busy_d[weff_i] = 1'b0;
        // Applied after the clear: a freshly issued producer outlives the retiring one.
        if (rsv_en_i && reff_i != ADDR_W'(ZERO_REG)) busy_d[reff_i] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with link redirect and RAW busy flags.
// Define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int LINK_REG = DEF_LINK_REG,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     jal,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     rsv_en,
    input  logic                     rsv_jal,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [ADDR_W-1:0] weff, reff;
    logic              wr_live;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

    assign weff    = ADDR_W'(eff_addr(jal, int'(wr_addr), LINK_REG));
    assign reff    = ADDR_W'(eff_addr(rsv_jal, int'(rsv_addr), LINK_REG));
    assign wr_live = wr_en && (weff != ADDR_W'(ZERO_REG));

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .weff_i     (weff),
        .rsv_en_i   (rsv_en),
        .reff_i     (reff),
        .busy_vec_o (busy_vec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         regs_q       <= '0;
        else if (wr_live) regs_q[weff] <= wr_data;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;
        logic              rbsy;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rdat = regs_q[ra];
            rbsy = busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
            // A same-cycle re-reserve keeps the operand pending, so no forwarding then.
            if (wr_live && weff == ra && !(rsv_en && reff == weff)) begin
                rdat = wr_data;
                rbsy = 1'b0;
            end
`endif
            if (ra == ADDR_W'(ZERO_REG)) begin
                rdat = '0;
                rbsy = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rdat;
        assign rd_busy[k]                  = rbsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed checks on a default regfile_mp plus a 4-port/64-bit/16-reg instance against a small model.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        wr_en, jal, rsv_en, rsv_jal;
    logic [4:0]  wr_addr, rsv_addr;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [31:0] busy_vec;

    logic         wr_en4, jal4, rsv_en4, rsv_jal4;
    logic [3:0]   wr_addr4, rsv_addr4;
    logic [63:0]  wr_data4;
    logic [15:0]  rd_addr4;
    logic [255:0] rd_data4;
    logic [3:0]   rd_busy4;
    logic [15:0]  busy_vec4;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .jal(jal), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rsv_en(rsv_en),
        .rsv_jal(rsv_jal), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
    );

    regfile_mp #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4), .LINK_REG(15)) u_dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en4), .jal(jal4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .rd_addr(rd_addr4), .rd_data(rd_data4), .rd_busy(rd_busy4), .rsv_en(rsv_en4),
        .rsv_jal(rsv_jal4), .rsv_addr(rsv_addr4), .busy_vec(busy_vec4)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rd2(input int a0, input int a1);
        rd_addr = {a1[4:0], a0[4:0]};
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        wr_en = 1'b0; jal = 1'b0; rsv_en = 1'b0; rsv_jal = 1'b0;
    endtask

    logic [63:0] m_regs [16];
    logic        m_busy [16];
    logic [3:0]  ra [4];
    logic [3:0]  we, re;
    logic [63:0] ed;
    logic        eb;
    logic [15:0] mvec;

    initial begin
        wr_en = 1'b0; jal = 1'b0; rsv_en = 1'b0; rsv_jal = 1'b0;
        wr_addr = '0; rsv_addr = '0; wr_data = '0; rd_addr = '0;
        wr_en4 = 1'b0; jal4 = 1'b0; rsv_en4 = 1'b0; rsv_jal4 = 1'b0;
        wr_addr4 = '0; rsv_addr4 = '0; wr_data4 = '0; rd_addr4 = '0;
        for (int i = 0; i < 16; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end

        // Reset held while a write and reserve are attempted
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_addr = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            rd2(i, 31 - i);
            chk($sformatf("rst_data%0d", i), rd_data, 64'h0);
            chk($sformatf("rst_busy%0d", i), rd_busy, 2'b00);
        end
        chk("rst_busyvec", busy_vec, 32'h0);
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
        @(posedge clk); #1;
        rd2(5, 5);
        chk("rst_r5", rd_data, 64'h0);

        // Register 0 is immutable and never busy
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        cyc();
        rd2(0, 0);
        chk("r0_data", rd_data, 64'h0);
        chk("r0_busy", busy_vec, 32'h0);

        // jal redirect to r31, r7 untouched
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000077;
        cyc();
        wr_en = 1'b1; jal = 1'b1; wr_addr = 5'd7; wr_data = 32'h00400010;
        cyc();
        rd2(31, 7);
        chk("jal_link", rd_data, {32'h00000077, 32'h00400010});

        // Scoreboard set / collide / clear on r9
        rsv_en = 1'b1; rsv_addr = 5'd9;
        cyc();
        rd2(9, 0);
        chk("sb_set_busy", rd_busy, 2'b01);
        chk("sb_set_vec", busy_vec, 32'h00000200);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; rsv_en = 1'b1; rsv_addr = 5'd9;
        cyc();
        rd2(0, 9);
        chk("sb_coll_busy", rd_busy, 2'b10);
        chk("sb_coll_data", rd_data, {32'h99, 32'h0});
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h999;
        cyc();
        rd2(9, 9);
        chk("sb_clr_busy", rd_busy, 2'b00);
        chk("sb_clr_data", rd_data, {32'h999, 32'h999});

        // rsv_jal reserves the link register; jal writeback retires it
        rsv_en = 1'b1; rsv_jal = 1'b1; rsv_addr = 5'd4;
        cyc();
        chk("rsvjal_vec", busy_vec, 32'h80000000);
        wr_en = 1'b1; jal = 1'b1; wr_addr = 5'd4; wr_data = 32'hCAFE;
        cyc();
        rd2(31, 4);
        chk("rsvjal_clr", busy_vec, 32'h0);
        chk("rsvjal_data", rd_data, {32'h0, 32'hCAFE});

        // r3 write while both ports read it (r3 reserved beforehand)
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11111111; rsv_en = 1'b1; rsv_addr = 5'd3;
        cyc();
        rd2(3, 3);
        chk("r3_pre_busy", rd_busy, 2'b11);
        chk("r3_pre_data", rd_data, 64'h11111111_11111111);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("r3_same_data", rd_data, 64'hA5A5A5A5_A5A5A5A5);
        chk("r3_same_busy", rd_busy, 2'b00);
`else
        chk("r3_same_data", rd_data, 64'h11111111_11111111);
        chk("r3_same_busy", rd_busy, 2'b11);
`endif
        cyc();
        rd2(3, 3);
        chk("r3_next_data", rd_data, 64'hA5A5A5A5_A5A5A5A5);
        chk("r3_next_busy", rd_busy, 2'b00);

        // Asynchronous reset mid-cycle discards reservations and data
        rsv_en = 1'b1; rsv_addr = 5'd12;
        cyc();
        chk("mid_vec_pre", busy_vec, 32'h00001000);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_vec_rst", busy_vec, 32'h0);
        rd2(3, 12);
        chk("mid_data_rst", rd_data, 64'h0);
        chk("mid_busy_rst", rd_busy, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Wide instance: link register 15 in a 16-entry file
        wr_en4 = 1'b1; jal4 = 1'b1; wr_addr4 = 4'd7; wr_data4 = 64'h01234567_89ABCDEF;
        @(posedge clk); #1;
        wr_en4 = 1'b0; jal4 = 1'b0;
        m_regs[15] = 64'h01234567_89ABCDEF;
        rd_addr4 = {4'd0, 4'd0, 4'd7, 4'd15};
        #1;
        chk("w_link15", rd_data4[63:0], 64'h01234567_89ABCDEF);
        chk("w_r7", rd_data4[127:64], 64'h0);

        for (int i = 0; i < 200; i++) begin
            wr_en4    = 1'($urandom_range(0, 1));
            jal4      = ($urandom_range(0, 3) == 0);
            wr_addr4  = 4'($urandom_range(0, 15));
            wr_data4  = {$urandom, $urandom};
            rsv_en4   = 1'($urandom_range(0, 1));
            rsv_jal4  = ($urandom_range(0, 5) == 0);
            rsv_addr4 = 4'($urandom_range(0, 15));
            we = jal4 ? 4'd15 : wr_addr4;
            re = rsv_jal4 ? 4'd15 : rsv_addr4;
            for (int p = 0; p < 4; p++) begin
                ra[p] = ($urandom_range(0, 3) == 0) ? we : 4'($urandom_range(0, 15));
                rd_addr4[p*4 +: 4] = ra[p];
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                ed = (ra[p] == 4'd0) ? 64'h0 : m_regs[ra[p]];
                eb = (ra[p] != 4'd0) && m_busy[ra[p]];
`ifdef REGFILE_BYPASS_EN
                if (wr_en4 && we != 4'd0 && we == ra[p] && !(rsv_en4 && re == we)) begin
                    ed = wr_data4;
                    eb = 1'b0;
                end
`endif
                chk($sformatf("rnd%0d_p%0d_data", i, p), rd_data4[p*64 +: 64], ed);
                chk($sformatf("rnd%0d_p%0d_busy", i, p), rd_busy4[p], eb);
            end
            if (wr_en4 && we != 4'd0) begin m_regs[we] = wr_data4; m_busy[we] = 1'b0; end
            if (rsv_en4 && re != 4'd0) m_busy[re] = 1'b1;
            @(posedge clk); #1;
        end
        wr_en4 = 1'b0; rsv_en4 = 1'b0;
        for (int r = 0; r < 16; r++) mvec[r] = m_busy[r];
        chk("rnd_busyvec", busy_vec4, mvec);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the MIPS pipeline decode stage.
- Supports configurable data width, register count and read-port count.
- Jump-and-link writes are redirected to a configurable link register.
- An integrated busy-bit scoreboard flags read operands that have an outstanding writer, so decode can stall on RAW hazards without a separate hazard unit.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- NUM_REGS, 32, number of architectural registers; must be a power of two and at least 2.
- NUM_RD, 2, number of independent combinational read ports; range 1 to 4.
- LINK_REG, 31, register index written when jal is high.
- ADDR_W, $clog2(NUM_REGS), derived address width; not for override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- wr_en  in  1  writeback strobe.
- jal  in  1  with wr_en: redirect the write to LINK_REG and ignore wr_addr.
- wr_addr  in  ADDR_W  writeback register index.
- wr_data  in  DATA_W  writeback data.
- rd_addr  in  NUM_RD x ADDR_W  read indices, packed; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD x DATA_W  read data, packed similarly.
- rd_busy  out  NUM_RD  port k operand has an outstanding writer.
- rsv_en  in  1  reserve strobe from issue: mark the destination busy.
- rsv_jal  in  1  with rsv_en: reserve LINK_REG and ignore rsv_addr.
- rsv_addr  in  ADDR_W  destination being reserved.
- busy_vec  out  NUM_REGS  raw scoreboard state, for debug and verification.

Behaviour:
- Interface clocking: one clock; reset is asynchronous and active-low.
- Reset (rst=0): all registers clear to 0 and all busy bits clear immediately, independent of clk. rd_data reads 0 and rd_busy reads 0 on every port. A reset asserted mid-operation discards all reservations.
- Effective write address: weff = jal ? LINK_REG : wr_addr. Effective reserve address: reff = rsv_jal ? LINK_REG : rsv_addr.
- Write: on posedge clk with wr_en=1 and weff!=0, regs[weff] <= wr_data. A write to register 0 is dropped.
- Register 0: reads 0 on every port at all times and is never busy. A reserve to register 0 is ignored.
- Read: combinational, zero latency; rd_data[k] = regs[rd_addr[k]].
- Any number of ports may read the same address simultaneously.
- Scoreboard, on posedge clk:
  - wr_en=1 with weff!=0 clears busy[weff].
  - rsv_en=1 with reff!=0 sets busy[reff].
  - reff==weff in the same cycle: set wins, because a new producer has been issued after the old one retires.
  - Reserving an already-busy register leaves it busy (single-bit scoreboard, no counting).
  - A write to a non-busy register is legal and writes the data normally.
- rd_busy[k] = busy[rd_addr[k]] from the registered state (subject to the bypass override below). Always 0 for address 0.
- Out-of-range addresses do not occur, because NUM_REGS is a power of two.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: same-cycle write-through. If wr_en=1, weff!=0 and weff==rd_addr[k], then rd_data[k]=wr_data and rd_busy[k]=0 in the same cycle, unless rsv_en reserves that same register this cycle.
- Undefined: reads return the pre-edge register contents. A written value is visible the cycle after the edge, and rd_busy[k] drops the cycle after writeback.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W, NUM_REGS and LINK_REG;
  - the ZERO_REG constant;
  - function eff_addr(jal, addr) for the link redirect.
- Sub-module regfile_scoreboard owns the busy vector and its set/clear priority. It takes weff, reff and the strobes, and outputs busy_vec.
- The top level instances regfile_scoreboard and implements storage, read muxes and bypass.

Test Plan:
- Reset, then read all registers on both ports; write 0xDEADBEEF to r5; release reset mid-cycle -> every rd_data=0, every busy=0, and r5 still reads 0 after reset.
- Write 0x12345678 to r0; read r0 -> rd_data=0; rsv_addr=0 -> busy_vec[0]=0.
- jal=1, wr_addr=7, wr_data=0x00400010 -> r31 = 0x00400010 and r7 unchanged. Repeat with LINK_REG=15 and NUM_REGS=16 -> r15 is written.
- rsv_en on r9; next cycle read r9 -> rd_busy=1. Writeback to r9 with rsv_en on r9 in the same cycle -> busy stays 1. Writeback alone -> busy clears.
- Write r3=0xA5A5A5A5 while port0 and port1 read r3:
  - with REGFILE_BYPASS_EN -> same-cycle rd_data=0xA5A5A5A5 on both ports;
  - without it -> old value this cycle, new value next cycle.
- NUM_RD=4, DATA_W=64: 200 random writes, reads and reserves checked against a reference model -> all rd_data and rd_busy values match.
